// File: rtl/inner_fn_accum.sv
`timescale 1ns/1ps
// Purpose: custom-instruction front end; buffers float32 samples and sums f(x) over them with an external adder.
// Latency: PUSH/CLEAR/COUNT/empty RUN finish in 1 cycle; RUN takes N*(1+Lfn+1+Ladd)+1 cycles.
// Backpressure: start is ignored outside IDLE (no queuing); a full FIFO drops the sample and returns all-ones.
module inner_fn_accum #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [1:0]  n,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        fn_start,
    output logic [31:0] fn_dataa,
    input  logic        fn_done,
    input  logic [31:0] fn_result,
    output logic        add_start,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic        add_done,
    input  logic [31:0] add_result
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        IDLE, FN_ISSUE, FN_WAIT, ADD_ISSUE, ADD_WAIT, FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     result_q, result_d;
    logic            done_q, done_d;
    logic            fn_start_q, fn_start_d;
    logic [31:0]     fn_dataa_q, fn_dataa_d;
    logic            add_start_q, add_start_d;
    logic [31:0]     add_a_q, add_a_d;
    logic [31:0]     add_b_q, add_b_d;
    logic            mem_we;
    logic [31:0]     mem_q [DEPTH];

    // Command decode and RUN sequencing; pulse outputs default low every enabled cycle.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        count_d     = count_q;
        acc_d       = acc_q;
        result_d    = result_q;
        done_d      = 1'b0;
        fn_start_d  = 1'b0;
        fn_dataa_d  = fn_dataa_q;
        add_start_d = 1'b0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                // Refusing start while done is still high keeps done from
                // ever being asserted on two consecutive enabled cycles.
                if (start && !done_q) begin
                    case (n)
                        2'd0: begin
                            if (count_q != CW'(DEPTH)) begin
                                mem_we   = 1'b1;
                                wr_d     = wr_q + AW'(1);
                                count_d  = count_q + CW'(1);
                                result_d = 32'(count_q) + 32'd1;
                            end else begin
                                result_d = 32'hFFFF_FFFF;
                            end
                            done_d = 1'b1;
                        end
                        2'd1: begin
                            if (count_q == '0) begin
                                result_d = acc_q;
                                done_d   = 1'b1;
                            end else begin
                                state_d = FN_ISSUE;
                            end
                        end
                        2'd2: begin
                            wr_d     = '0;
                            rd_d     = '0;
                            count_d  = '0;
                            acc_d    = '0;
                            result_d = '0;
                            done_d   = 1'b1;
                        end
                        default: begin
                            result_d = 32'(count_q);
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            FN_ISSUE: begin
                fn_dataa_d = mem_q[rd_q];
                rd_d       = rd_q + AW'(1);
                count_d    = count_q - CW'(1);
                fn_start_d = 1'b1;
                state_d    = FN_WAIT;
            end
            FN_WAIT: begin
                if (fn_done) begin
                    add_b_d = fn_result;
                    state_d = ADD_ISSUE;
                end
            end
            ADD_ISSUE: begin
                add_a_d     = acc_q;
                add_start_d = 1'b1;
                state_d     = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (add_done) begin
                    acc_d   = add_result;
                    state_d = (count_q != '0) ? FN_ISSUE : FINISH;
                end
            end
            FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                acc_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; clk_en low freezes everything, reset needs clk_en high.
    always_ff @(posedge clock) begin
        if (clk_en) begin
            if (!reset_n) begin
                state_q     <= IDLE;
                wr_q        <= '0;
                rd_q        <= '0;
                count_q     <= '0;
                acc_q       <= '0;
                result_q    <= '0;
                done_q      <= 1'b0;
                fn_start_q  <= 1'b0;
                fn_dataa_q  <= '0;
                add_start_q <= 1'b0;
                add_a_q     <= '0;
                add_b_q     <= '0;
            end else begin
                state_q     <= state_d;
                wr_q        <= wr_d;
                rd_q        <= rd_d;
                count_q     <= count_d;
                acc_q       <= acc_d;
                result_q    <= result_d;
                done_q      <= done_d;
                fn_start_q  <= fn_start_d;
                fn_dataa_q  <= fn_dataa_d;
                add_start_q <= add_start_d;
                add_a_q     <= add_a_d;
                add_b_q     <= add_b_d;
            end
        end
    end

    // Sample storage; contents beyond the pointers are don't-care, so no reset.
    always_ff @(posedge clock) begin
        if (clk_en && reset_n && mem_we) begin
            mem_q[wr_q] <= dataa;
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign fn_start  = fn_start_q;
    assign fn_dataa  = fn_dataa_q;
    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

endmodule

// File: tb/tb_inner_fn_accum.sv
`timescale 1ns/1ps
// Purpose: directed bench for inner_fn_accum with fn/adder models and a result scoreboard.
// Latency: models respond LFN / LADD enabled cycles after their start pulse.
// Backpressure: models freeze along with clk_en so a stalled RUN resumes cleanly.
module tb_inner_fn_accum;

    localparam int DEPTH = 16;
    localparam int CW    = 5;
    localparam int LFN   = 4;
    localparam int LADD  = 3;

    logic        clock = 1'b0;
    logic        reset_n, clk_en, start;
    logic [1:0]  n;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done, fn_start, add_start;
    logic [31:0] fn_dataa, add_a, add_b;
    logic        fn_done = 1'b0;
    logic [31:0] fn_result = '0;
    logic        add_done = 1'b0;
    logic [31:0] add_result = '0;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] fnexp_q[$];
    logic [31:0] mfifo[$];
    logic        en_s;
    logic        prev_done = 1'b0;

    inner_fn_accum #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock), .reset_n(reset_n), .clk_en(clk_en), .start(start), .n(n),
        .dataa(dataa), .result(result), .done(done), .fn_start(fn_start),
        .fn_dataa(fn_dataa), .fn_done(fn_done), .fn_result(fn_result),
        .add_start(add_start), .add_a(add_a), .add_b(add_b),
        .add_done(add_done), .add_result(add_result)
    );

    always #5 clock = ~clock;

    // float32 <-> real for normal values and zero
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [31:0] t;
        logic [28:0] low;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        t   = {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
        low = d[28:0];
        if (low > 29'h1000_0000 || (low == 29'h1000_0000 && t[0])) t = t + 32'd1;
        return t;
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] fn_f(input logic [31:0] x);
        case (x)
            32'h41c8_0000: return 32'h43de_ea9d;
            32'h4248_0000: return 32'h4501_b0c0;
            default:       return fadd(x, x);
        endcase
    endfunction

    function automatic logic [31:0] smp(input int k);
        return r2f(real'(k) + 0.25);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inner_fn_lat model: checks sample order, answers LFN enabled cycles later
    always @(posedge clock) begin
        logic en, st;
        logic [31:0] x;
        logic [31:0] val;
        int cnt;
        en = clk_en; st = fn_start; x = fn_dataa;
        #1;
        if (en === 1'b1) begin
            fn_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin fn_done = 1'b1; fn_result = val; end
            end
            if (st === 1'b1) begin
                total++;
                assert (fnexp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL fn_extra observed=%0h expected=no_start", x);
                end
                if (fnexp_q.size() != 0) chk("fn_order", 128'(x), 128'(fnexp_q.pop_front()));
                val = fn_f(x);
                cnt = LFN;
            end
        end else if (en !== 1'b0) begin
            cnt = 0;
        end
    end

    // float adder model: answers LADD enabled cycles after add_start
    always @(posedge clock) begin
        logic en, st;
        logic [31:0] val;
        int cnt;
        en = clk_en; st = add_start;
        val = (st === 1'b1) ? fadd(add_a, add_b) : val;
        #1;
        if (en === 1'b1) begin
            add_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin add_done = 1'b1; add_result = val; end
            end
            if (st === 1'b1) cnt = LADD;
        end else if (en !== 1'b0) begin
            cnt = 0;
        end
    end

    always @(posedge clock) en_s = clk_en;

    // scoreboard: every enabled done pops one expected result
    always @(negedge clock) begin
        if (en_s === 1'b1) begin
            if (done === 1'b1) begin
                chk("done_gap", 128'(prev_done), 128'(0));
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL done_extra observed=%0h expected=no_done", result);
                end
                if (exp_q.size() != 0) chk("result", 128'(result), 128'(exp_q.pop_front()));
            end
            prev_done = (done === 1'b1);
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (exp_q.size() == 0) break;
            @(negedge clock);
        end
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic cmd(input logic [1:0] c, input logic [31:0] d, input logic [31:0] e);
        @(negedge clock);
        start = 1'b1; n = c; dataa = d;
        exp_q.push_back(e);
        @(negedge clock);
        start = 1'b0;
        #1;
        chk("done_lat1", 128'(done), 128'(1));
        wait_drain();
    endtask

    task automatic push(input logic [31:0] d);
        logic [31:0] e;
        if (mfifo.size() < DEPTH) begin
            mfifo.push_back(d);
            e = 32'(mfifo.size());
        end else begin
            e = 32'hFFFF_FFFF;
        end
        cmd(2'd0, d, e);
    endtask

    task automatic run(input bit drain, input bit expect_done);
        logic [31:0] s;
        logic [31:0] x;
        s = 32'd0;
        while (mfifo.size() > 0) begin
            x = mfifo.pop_front();
            fnexp_q.push_back(x);
            s = fadd(s, fn_f(x));
        end
        @(negedge clock);
        start = 1'b1; n = 2'd1;
        if (expect_done) exp_q.push_back(s);
        @(negedge clock);
        start = 1'b0;
        if (drain) wait_drain();
    endtask

    task automatic wait_high(input string tag, input bit use_add);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if ((use_add ? add_start : fn_start) === 1'b1) begin seen = 1'b1; break; end
        end
        chk(tag, 128'(seen), 128'(1));
    endtask

    initial begin
        logic [2:0]   snap_c;
        logic [127:0] snap_d;
        reset_n = 1'b0; clk_en = 1'b1; start = 1'b0; n = 2'd0; dataa = '0;

        // reset holds all pulse outputs and result low
        repeat (3) begin
            @(negedge clock);
            chk("rst_fn_start", 128'(fn_start), 128'(0));
            chk("rst_add_start", 128'(add_start), 128'(0));
            chk("rst_done", 128'(done), 128'(0));
            chk("rst_result", 128'(result), 128'(0));
        end
        reset_n = 1'b1;
        cmd(2'd3, '0, 32'd0);

        // two-sample RUN: 25.0 then 50.0
        push(32'h41c8_0000);
        push(32'h4248_0000);
        run(1'b1, 1'b1);
        cmd(2'd3, '0, 32'd0);

        // overfill: counts 1..16 then all-ones
        for (int k = 0; k < DEPTH + 1; k++) push(smp(k));
        cmd(2'd3, '0, 32'd16);
        mfifo.delete();
        cmd(2'd2, '0, 32'd0);

        // pointer wrap across two RUNs
        for (int k = 0; k < 12; k++) push(smp(100 + k));
        run(1'b1, 1'b1);
        for (int k = 0; k < 12; k++) push(smp(200 + 3 * k));
        run(1'b1, 1'b1);

        // start ignored in FN_WAIT, then a clk_en freeze mid-RUN
        for (int k = 0; k < 3; k++) push(smp(300 + k));
        run(1'b0, 1'b1);
        wait_high("see_fn_start", 1'b0);
        start = 1'b1; n = 2'd0; dataa = 32'h1234_5678;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        snap_c = {done, fn_start, add_start};
        snap_d = {result, fn_dataa, add_a, add_b};
        clk_en = 1'b0;
        repeat (5) begin
            @(negedge clock);
            chk("freeze_ctl", 128'({done, fn_start, add_start}), 128'(snap_c));
            chk("freeze_dat", {result, fn_dataa, add_a, add_b}, snap_d);
        end
        clk_en = 1'b1;
        wait_drain();
        cmd(2'd3, '0, 32'd0);

        // reset in ADD_WAIT; the adder's late done must be ignored
        push(smp(400));
        push(smp(401));
        run(1'b0, 1'b0);
        wait_high("see_add_start", 1'b1);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        fnexp_q.delete();
        mfifo.delete();
        chk("abort_fn_start", 128'(fn_start), 128'(0));
        chk("abort_add_start", 128'(add_start), 128'(0));
        chk("abort_result", 128'(result), 128'(0));
        repeat (8) @(negedge clock);
        cmd(2'd3, '0, 32'd0);
        cmd(2'd1, '0, 32'd0);
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
